pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage pipeline. Drives the PC write enable, the IF/ID buffer write enable and flush, and the ID/EX bubble insert. It stalls fetch/decode on load-use hazards and squashes wrong-path instructions after a taken branch resolved in EX. It also keeps a saturating count of lost cycles for performance debug.

## Interface
- REG_W, 6, register specifier width
- STALL_CYCLES, 1, total bubble cycles per load-use hazard (≥1)
- FLUSH_CYCLES, 2, total squash cycles per taken branch (≥1)
- clock  in  1  rising-edge clock; the IF/ID buffer latches on the falling edge of the same clock
- reset  in  1  synchronous, active-high
- id_rs  in  REG_W  source register 1 of the instruction in ID
- id_rt  in  REG_W  source register 2 of the instruction in ID
- id_rs_valid  in  1  ID instruction reads id_rs
- id_rt_valid  in  1  ID instruction reads id_rt
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  REG_W  destination register of the instruction in EX
- branch_taken  in  1  branch/jump in EX resolved taken this cycle
- pc_write  out  1  PC may update
- ifid_write  out  1  IF/ID buffer may load
- ifid_flush  out  1  IF/ID buffer loads a NOP
- idex_bubble  out  1  ID/EX loads control-zero (bubble)
- ctrl_state  out  2  current state: 0 RUN, 1 STALL, 2 FLUSH
- lost_cycles  out  16  saturating count of cycles with pc_write=0 or ifid_flush=1

## Operation
- Hazard term: `load_use = ex_mem_read & ((id_rs_valid & id_rs==ex_rd) | (id_rt_valid & id_rt==ex_rd))`. Register 0 is not special.
- Registered state: the 2-bit FSM, an 8-bit down-counter `cnt`, and lost_cycles. All outputs are combinational from state, cnt and inputs.
- RUN, normal operation: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
- RUN with branch_taken (has priority over load_use):
  - Outputs: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1.
  - If FLUSH_CYCLES>1: next state FLUSH, cnt←FLUSH_CYCLES−1. Otherwise stay in RUN.
- RUN with load_use and no branch_taken:
  - Outputs: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1.
  - If STALL_CYCLES>1: next state STALL, cnt←STALL_CYCLES−1. Otherwise stay in RUN.
- STALL:
  - Outputs same as the load_use case in RUN.
  - cnt decrements each cycle. At cnt==1, next state is RUN.
  - branch_taken and load_use are ignored, because EX holds a bubble.
- FLUSH:
  - Outputs same as the branch case in RUN.
  - cnt decrements each cycle. At cnt==1, next state is RUN.
  - branch_taken and load_use are ignored, because the instructions in flight are wrong-path.
- lost_cycles increments by 1 in any cycle where (pc_write==0 | ifid_flush==1), and saturates at 16'hFFFF.
- Illegal ctrl_state value 3 behaves as RUN and transitions to RUN.

## Timing
- Reset, sampled on the rising edge: state←RUN, cnt←0, lost_cycles←0.
- While reset=1, outputs are forced: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1.
- Reset wins over every in-flight stall or flush. The first cycle after deassertion is plain RUN, with no residual squash.
- Decisions are same-cycle (Mealy) in RUN. Hazard to control output has zero latency, so downstream registers act on the next rising edge. The IF/ID buffer acts on the next falling edge.
- Total stall length per hazard is exactly STALL_CYCLES cycles. Total squash length per branch is exactly FLUSH_CYCLES cycles, counting the RUN detection cycle.
- After the final stall or flush cycle, the next cycle re-evaluates hazards fresh in RUN. Back-to-back hazards therefore stall continuously with no gap.
- branch_taken and load_use in the same cycle: flush wins. The load-use instruction is squashed, so no stall occurs.
- cnt is only meaningful in STALL and FLUSH. It is width-sufficient for parameter values up to 255.

## Test plan
- Reset mid-FLUSH:
  - Stimulus: FLUSH_CYCLES=3; assert branch_taken for 1 cycle; assert reset on the 2nd flush cycle.
  - Required response: outputs take the forced values while reset=1; ctrl_state=0, lost_cycles=0 after reset; the cycle after deassertion has ifid_flush=0.
- Load-use on rs:
  - Stimulus: ex_mem_read=1, ex_rd=5, id_rs=5, id_rs_valid=1, STALL_CYCLES=1.
  - Required response: exactly 1 cycle with pc_write=0, ifid_write=0, idex_bubble=1; lost_cycles=1.
- Multi-cycle stall and false hazard:
  - Stimulus: STALL_CYCLES=3, rt match with id_rt_valid=1.
  - Required response: 3 consecutive stall cycles (ctrl_state 0,1,1), then RUN.
  - Stimulus: same rt match with id_rt_valid=0.
  - Required response: no stall.
- Taken branch, default parameters:
  - Stimulus: branch_taken for 1 cycle.
  - Required response: ifid_flush=1 and idex_bubble=1 for 2 cycles, pc_write=1 throughout; load_use asserted during the 2nd cycle is ignored.
- Simultaneous events:
  - Stimulus: branch_taken=1 and load_use=1 in the same RUN cycle.
  - Required response: flush behaviour only; pc_write stays 1.
- Saturation:
  - Stimulus: hold load_use for 70000 cycles.
  - Required response: lost_cycles holds at 16'hFFFF without wrapping.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline.
// Stalls on load-use, squashes wrong-path work after taken branches.
module pipeline_hazard_ctrl #(
  parameter int REG_W        = 6,
  parameter int STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_valid,
  input  logic             id_rt_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       ctrl_state,
  output logic [15:0]      lost_cycles
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [7:0] STALL_INIT = 8'(STALL_CYCLES - 1);
  localparam logic [7:0] FLUSH_INIT = 8'(FLUSH_CYCLES - 1);
  localparam bit         STALL_MULTI = (STALL_CYCLES > 1);
  localparam bit         FLUSH_MULTI = (FLUSH_CYCLES > 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
  logic [15:0] r_lost;
  logic        w_load_use;
  logic        w_lost;

  assign w_load_use = ex_mem_read &
    ((id_rs_valid & (id_rs == ex_rd)) |
     (id_rt_valid & (id_rt == ex_rd)));

  assign w_lost = ~pc_write | ifid_flush;

  // State, countdown and lost-cycle counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_cnt   <= 8'd0;
      r_lost  <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_lost && (r_lost != 16'hFFFF))
        r_lost <= r_lost + 16'd1;
    end
  end

  // Next-state and Mealy control outputs; reset forces a safe squash
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    case (r_state)
      ST_STALL: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        w_cnt_nxt   = r_cnt - 8'd1;
        if (r_cnt == 8'd1)
          w_state_nxt = ST_RUN;
      end
      ST_FLUSH: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        w_cnt_nxt   = r_cnt - 8'd1;
        if (r_cnt == 8'd1)
          w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_RUN;
        if (branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (FLUSH_MULTI) begin
            w_state_nxt = ST_FLUSH;
            w_cnt_nxt   = FLUSH_INIT;
          end
        end else if (w_load_use) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          if (STALL_MULTI) begin
            w_state_nxt = ST_STALL;
            w_cnt_nxt   = STALL_INIT;
          end
        end
      end
    endcase
    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  assign ctrl_state  = r_state;
  assign lost_cycles = r_lost;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl.
// Two instances: default parameters and STALL=3/FLUSH=3.
module tb_pipeline_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] id_rs, id_rt, ex_rd;
  logic       id_rs_valid, id_rt_valid;
  logic       ex_mem_read, branch_taken;

  logic        a_pc, a_ifw, a_fl, a_bub;
  logic [1:0]  a_st;
  logic [15:0] a_lost;
  logic        b_pc, b_ifw, b_fl, b_bub;
  logic [1:0]  b_st;
  logic [15:0] b_lost;

  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  pipeline_hazard_ctrl #(
    .REG_W(6), .STALL_CYCLES(1), .FLUSH_CYCLES(2)
  ) u_a (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_valid(id_rs_valid), .id_rt_valid(id_rt_valid),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .branch_taken(branch_taken),
    .pc_write(a_pc), .ifid_write(a_ifw),
    .ifid_flush(a_fl), .idex_bubble(a_bub),
    .ctrl_state(a_st), .lost_cycles(a_lost)
  );

  pipeline_hazard_ctrl #(
    .REG_W(6), .STALL_CYCLES(3), .FLUSH_CYCLES(3)
  ) u_b (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_valid(id_rs_valid), .id_rt_valid(id_rt_valid),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .branch_taken(branch_taken),
    .pc_write(b_pc), .ifid_write(b_ifw),
    .ifid_flush(b_fl), .idex_bubble(b_bub),
    .ctrl_state(b_st), .lost_cycles(b_lost)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    id_rs = 6'd0; id_rt = 6'd0; ex_rd = 6'd0;
    id_rs_valid = 1'b0; id_rt_valid = 1'b0;
    ex_mem_read = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic lu_rs(input logic [5:0] r);
    ex_mem_read = 1'b1; ex_rd = r;
    id_rs = r; id_rs_valid = 1'b1;
  endtask

  initial begin
    clr();
    reset = 1'b1;
    @(negedge clock);
    chk("rst_pc", a_pc, 0);
    chk("rst_ifw", a_ifw, 0);
    chk("rst_fl", a_fl, 1);
    chk("rst_bub", a_bub, 1);
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_st", a_st, 0);
    chk("post_rst_lost", a_lost, 0);
    chk("post_rst_pc", a_pc, 1);
    chk("post_rst_fl", a_fl, 0);

    // load-use on rs, single-cycle stall
    tick();
    lu_rs(6'd5);
    @(negedge clock);
    chk("lu1_pc", a_pc, 0);
    chk("lu1_ifw", a_ifw, 0);
    chk("lu1_bub", a_bub, 1);
    chk("lu1_fl", a_fl, 0);
    tick();
    clr();
    @(negedge clock);
    chk("lu1_after_pc", a_pc, 1);
    chk("lu1_after_st", a_st, 0);
    chk("lu1_lost", a_lost, 1);

    // multi-cycle stall on rt (instance b)
    tick();
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 6'd7;
    id_rt = 6'd7; id_rt_valid = 1'b1;
    @(negedge clock);
    chk("ms0_st", b_st, 0);
    chk("ms0_pc", b_pc, 0);
    chk("ms0_bub", b_bub, 1);
    tick();
    clr();
    @(negedge clock);
    chk("ms1_st", b_st, 1);
    chk("ms1_pc", b_pc, 0);
    tick();
    @(negedge clock);
    chk("ms2_st", b_st, 1);
    chk("ms2_ifw", b_ifw, 0);
    tick();
    @(negedge clock);
    chk("ms3_st", b_st, 0);
    chk("ms3_pc", b_pc, 1);
    chk("ms_lost", b_lost, 3);

    // false hazard: match but rt not read
    tick();
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 6'd7;
    id_rt = 6'd7; id_rt_valid = 1'b0;
    id_rs = 6'd9; id_rs_valid = 1'b1;
    @(negedge clock);
    chk("fh_pc_b", b_pc, 1);
    chk("fh_pc_a", a_pc, 1);
    chk("fh_bub", b_bub, 0);
    tick();
    clr();
    @(negedge clock);
    chk("fh_st", b_st, 0);

    // taken branch, default parameters
    do_reset();
    branch_taken = 1'b1;
    @(negedge clock);
    chk("br0_fl", a_fl, 1);
    chk("br0_bub", a_bub, 1);
    chk("br0_pc", a_pc, 1);
    tick();
    clr();
    lu_rs(6'd12);
    @(negedge clock);
    chk("br1_st", a_st, 2);
    chk("br1_fl", a_fl, 1);
    chk("br1_pc", a_pc, 1);
    chk("br1_ifw", a_ifw, 1);
    tick();
    clr();
    @(negedge clock);
    chk("br2_st", a_st, 0);
    chk("br2_fl", a_fl, 0);
    chk("br2_bub", a_bub, 0);
    chk("br_lost", a_lost, 2);

    // branch and load-use together: flush wins
    do_reset();
    branch_taken = 1'b1;
    lu_rs(6'd3);
    @(negedge clock);
    chk("sim_pc", a_pc, 1);
    chk("sim_ifw", a_ifw, 1);
    chk("sim_fl", a_fl, 1);
    tick();
    clr();
    @(negedge clock);
    chk("sim1_st", a_st, 2);
    chk("sim1_pc", a_pc, 1);

    // reset in the middle of a 3-cycle flush (instance b)
    tick();
    do_reset();
    branch_taken = 1'b1;
    @(negedge clock);
    chk("rf0_fl", b_fl, 1);
    tick();
    clr();
    @(negedge clock);
    chk("rf1_st", b_st, 2);
    reset = 1'b1;
    #1;
    chk("rf_rst_pc", b_pc, 0);
    chk("rf_rst_ifw", b_ifw, 0);
    chk("rf_rst_fl", b_fl, 1);
    chk("rf_rst_bub", b_bub, 1);
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("rf_st", b_st, 0);
    chk("rf_lost", b_lost, 0);
    chk("rf_fl", b_fl, 0);
    chk("rf_pc", b_pc, 1);

    // saturation of lost_cycles under continuous load-use
    tick();
    do_reset();
    lu_rs(6'd1);
    repeat (65534) @(posedge clock);
    @(negedge clock);
    chk("sat_fffe", a_lost, 16'hFFFE);
    @(posedge clock);
    @(negedge clock);
    chk("sat_ffff", a_lost, 16'hFFFF);
    repeat (4465) @(posedge clock);
    @(negedge clock);
    chk("sat_hold_a", a_lost, 16'hFFFF);
    chk("sat_hold_b", b_lost, 16'hFFFF);
    chk("sat_pc", a_pc, 0);
    clr();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
